// File: rtl/camera_axi_regs_if.sv
// AXI4-Lite slave bus bundle for the camera register block.
interface camera_axi_regs_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
           S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
           S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
           S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
           S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/camera_axi_regs.sv
// AXI4-Lite register file for the OV7670 capture core: control, config, status, frame count.
// Optional CAMERA_AXI_IRQ_EN compiles in the frame_done interrupt; otherwise irq is tied low.
module camera_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  camera_axi_regs_if.slave              s_axi,
  output logic                          capture_en,
  output logic                          cam_soft_rst,
  output logic [C_S_AXI_DATA_WIDTH-1:0] sccb_cfg,
  input  logic                          frame_done,
  input  logic                          cam_busy,
  output logic                          irq
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  logic                          rdy_en;
  logic                          aw_full, w_full, bvalid, rvalid;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [DW-1:0]                 w_data_q, rdata, rd_mux;
  logic [SW-1:0]                 w_strb_q;
  logic [DW-1:0]                 ctrl_q, cfg_q, mask_q, scratch_q, cnt_q;
  logic                          done_q, irq_q, srst_q;

  logic                          aw_hs, w_hs, ar_hs, wr_go, w1c;
  logic [2:0]                    wr_idx;
  logic [DW-1:0]                 wr_data;
  logic [SW-1:0]                 wr_strb;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    for (int i = 0; i < SW; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  // rdy_en holds the READYs low until the first edge after reset release
  assign s_axi.S_AXI_AWREADY = rdy_en & ~aw_full & ~bvalid;
  assign s_axi.S_AXI_WREADY  = rdy_en & ~w_full & ~bvalid;
  assign s_axi.S_AXI_ARREADY = rdy_en & ~rvalid;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RDATA   = rdata;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  assign aw_hs   = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
  assign w_hs    = s_axi.S_AXI_WVALID & s_axi.S_AXI_WREADY;
  assign ar_hs   = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
  assign wr_go   = (aw_full | aw_hs) & (w_full | w_hs);
  assign wr_idx  = aw_full ? aw_addr_q[4:2] : s_axi.S_AXI_AWADDR[4:2];
  assign wr_data = w_full ? w_data_q : s_axi.S_AXI_WDATA;
  assign wr_strb = w_full ? w_strb_q : s_axi.S_AXI_WSTRB;
  assign w1c     = wr_go & (wr_idx == 3'd4) & wr_strb[0] & wr_data[0];

  assign capture_en   = ctrl_q[0];
  assign cam_soft_rst = srst_q;
  assign sccb_cfg     = cfg_q;
  assign irq          = irq_q;

  logic unused;
  assign unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, aw_addr_q[1:0],
                    s_axi.S_AXI_ARADDR[1:0]};

  always_comb begin
    rd_mux = '0;
    case (s_axi.S_AXI_ARADDR[4:2])
      3'd0:    rd_mux = ctrl_q;
      3'd1:    rd_mux = cfg_q;
      3'd2:    rd_mux = mask_q;
      3'd3:    rd_mux = scratch_q;
      3'd4:    rd_mux = {{(DW-2){1'b0}}, cam_busy, done_q};
      3'd5:    rd_mux = cnt_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdy_en    <= 1'b0;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (wr_go) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
      end else begin
        if (aw_hs) begin
          aw_full   <= 1'b1;
          aw_addr_q <= s_axi.S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_full   <= 1'b1;
          w_data_q <= s_axi.S_AXI_WDATA;
          w_strb_q <= s_axi.S_AXI_WSTRB;
        end
        if (bvalid && s_axi.S_AXI_BREADY) bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_q    <= '0;
      cfg_q     <= '0;
      mask_q    <= '0;
      scratch_q <= '0;
      srst_q    <= 1'b0;
    end else begin
      srst_q <= 1'b0;
      if (wr_go) begin
        case (wr_idx)
          3'd0: begin
            // soft-reset bit never stored; it only fires the pulse
            ctrl_q <= merge(ctrl_q, wr_data, wr_strb) & ~{{(DW-2){1'b0}}, 2'b10};
            srst_q <= wr_strb[0] & wr_data[1];
          end
          3'd1:    cfg_q     <= merge(cfg_q, wr_data, wr_strb);
          3'd2:    mask_q    <= merge(mask_q, wr_data, wr_strb);
          3'd3:    scratch_q <= merge(scratch_q, wr_data, wr_strb);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      done_q <= 1'b0;
      cnt_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (frame_done) begin
        done_q <= 1'b1;
        cnt_q  <= cnt_q + 1'b1;
      end else if (w1c) begin
        done_q <= 1'b0;
      end
`ifdef CAMERA_AXI_IRQ_EN
      irq_q <= done_q & mask_q[0];
`else
      irq_q <= 1'b0;
`endif
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_mux;
    end else if (rvalid && s_axi.S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_camera_axi_regs.sv
// Directed bench for camera_axi_regs: register sweep, strobes, W1C/IRQ, stalls, reset.
module tb_camera_axi_regs;
`ifdef CAMERA_AXI_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        frame_done = 1'b0;
  logic        cam_busy = 1'b0;
  logic        capture_en, cam_soft_rst, irq;
  logic [31:0] sccb_cfg;
  int          checks = 0;
  int          errors = 0;

  camera_axi_regs_if s_axi ();

  camera_axi_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(s_axi),
    .capture_en(capture_en), .cam_soft_rst(cam_soft_rst), .sccb_cfg(sccb_cfg),
    .frame_done(frame_done), .cam_busy(cam_busy), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    bit awd, wd, aw_go, w_go;
    @(negedge ACLK);
    s_axi.S_AXI_AWADDR = a; s_axi.S_AXI_AWVALID = 1'b1;
    s_axi.S_AXI_WDATA = d; s_axi.S_AXI_WSTRB = s; s_axi.S_AXI_WVALID = 1'b1;
    s_axi.S_AXI_BREADY = 1'b1;
    awd = 0; wd = 0; n = 0;
    while (!(awd && wd) && n < 40) begin
      aw_go = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
      w_go  = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
      @(negedge ACLK);
      if (aw_go) begin s_axi.S_AXI_AWVALID = 1'b0; awd = 1; end
      if (w_go)  begin s_axi.S_AXI_WVALID = 1'b0; wd = 1; end
      n++;
    end
    while (!s_axi.S_AXI_BVALID && n < 40) begin @(negedge ACLK); n++; end
    checks++;
    if (s_axi.S_AXI_BVALID !== 1'b1) begin
      errors++; $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, s_axi.S_AXI_BVALID);
    end
    resp = s_axi.S_AXI_BRESP;
    s_axi.S_AXI_AWVALID = 1'b0; s_axi.S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    s_axi.S_AXI_ARADDR = a; s_axi.S_AXI_ARVALID = 1'b1; s_axi.S_AXI_RREADY = 1'b1;
    n = 0;
    while (!s_axi.S_AXI_ARREADY && n < 40) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    s_axi.S_AXI_ARVALID = 1'b0;
    while (!s_axi.S_AXI_RVALID && n < 40) begin @(negedge ACLK); n++; end
    checks++;
    if (s_axi.S_AXI_RVALID !== 1'b1) begin
      errors++; $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, s_axi.S_AXI_RVALID);
    end
    d = s_axi.S_AXI_RDATA; resp = s_axi.S_AXI_RRESP;
    @(negedge ACLK);
  endtask

  task automatic pulse_frame();
    @(negedge ACLK); frame_done = 1'b1;
    @(negedge ACLK); frame_done = 1'b0;
  endtask

  task automatic test_reset();
    s_axi.S_AXI_AWADDR = '0; s_axi.S_AXI_AWPROT = '0; s_axi.S_AXI_AWVALID = 1'b0;
    s_axi.S_AXI_WDATA = '0; s_axi.S_AXI_WSTRB = '0; s_axi.S_AXI_WVALID = 1'b0;
    s_axi.S_AXI_BREADY = 1'b0; s_axi.S_AXI_ARADDR = '0; s_axi.S_AXI_ARPROT = '0;
    s_axi.S_AXI_ARVALID = 1'b0; s_axi.S_AXI_RREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++;
    if ({s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_ARREADY, s_axi.S_AXI_BVALID,
         s_axi.S_AXI_RVALID, capture_en, cam_soft_rst, irq} !== 8'h00) begin
      errors++; $display("FAIL reset_ctl_outs got %b required 00000000", {s_axi.S_AXI_AWREADY,
        s_axi.S_AXI_WREADY, s_axi.S_AXI_ARREADY, s_axi.S_AXI_BVALID, s_axi.S_AXI_RVALID,
        capture_en, cam_soft_rst, irq});
    end
    checks++;
    if ({s_axi.S_AXI_RDATA, sccb_cfg, s_axi.S_AXI_BRESP, s_axi.S_AXI_RRESP} !== 68'h0) begin
      errors++; $display("FAIL reset_data_outs rdata=%h cfg=%h required 0", s_axi.S_AXI_RDATA, sccb_cfg);
    end
    ARESETN = 1'b1;
    #1;
    checks++;
    if (s_axi.S_AXI_AWREADY !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge awready=%b required 0", s_axi.S_AXI_AWREADY);
    end
    @(negedge ACLK);
    checks++;
    if ({s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_ARREADY} !== 3'b111) begin
      errors++; $display("FAIL ready_after_edge got %b required 111",
        {s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_ARREADY});
    end
  endtask

  task automatic test_sweep();
    logic [31:0] d;
    logic [1:0]  r, br;
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, br);
      checks++;
      if (br !== 2'b00) begin errors++; $display("FAIL sweep_bresp got %b required 00", br); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), d, r);
      checks++;
      if (d !== 32'(i + 1) || r !== 2'b00) begin
        errors++; $display("FAIL sweep_read idx=%0d got %h/%b required %h/00", i, d, r, i + 1);
      end
    end
    checks++;
    if (capture_en !== 1'b1 || sccb_cfg !== 32'h2) begin
      errors++; $display("FAIL sweep_outputs capture_en=%b cfg=%h required 1/00000002", capture_en, sccb_cfg);
    end
  endtask

  task automatic test_soft_rst();
    logic [31:0] d;
    logic [1:0]  r;
    int hi_cnt;
    bit first_hi;
    @(negedge ACLK);
    s_axi.S_AXI_AWADDR = 5'h00; s_axi.S_AXI_AWVALID = 1'b1;
    s_axi.S_AXI_WDATA = 32'h2; s_axi.S_AXI_WSTRB = 4'hF; s_axi.S_AXI_WVALID = 1'b1;
    s_axi.S_AXI_BREADY = 1'b1;
    hi_cnt = 0;
    @(negedge ACLK);
    s_axi.S_AXI_AWVALID = 1'b0; s_axi.S_AXI_WVALID = 1'b0;
    first_hi = cam_soft_rst;
    for (int k = 0; k < 5; k++) begin
      if (cam_soft_rst === 1'b1) hi_cnt++;
      @(negedge ACLK);
    end
    checks++;
    if (!first_hi || hi_cnt != 1) begin
      errors++; $display("FAIL soft_rst_pulse first=%b cycles=%0d required 1/1", first_hi, hi_cnt);
    end
    axi_read(5'h00, d, r);
    checks++;
    if (d !== 32'h0 || capture_en !== 1'b0) begin
      errors++; $display("FAIL soft_rst_ctrl got %h capture_en=%b required 00000000/0", d, capture_en);
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(5'h04, 32'h0, 4'hF, r);
    @(negedge ACLK);
    s_axi.S_AXI_WDATA = 32'hA5A5A5A5; s_axi.S_AXI_WSTRB = 4'b0011; s_axi.S_AXI_WVALID = 1'b1;
    s_axi.S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    s_axi.S_AXI_WVALID = 1'b0;
    checks++;
    if (s_axi.S_AXI_WREADY !== 1'b0 || s_axi.S_AXI_BVALID !== 1'b0) begin
      errors++; $display("FAIL w_buffered wready=%b bvalid=%b required 0/0",
        s_axi.S_AXI_WREADY, s_axi.S_AXI_BVALID);
    end
    @(negedge ACLK);
    @(negedge ACLK);
    s_axi.S_AXI_AWADDR = 5'h04; s_axi.S_AXI_AWVALID = 1'b1;
    checks++;
    if (s_axi.S_AXI_BVALID !== 1'b0 || sccb_cfg !== 32'h0) begin
      errors++; $display("FAIL w_early_update bvalid=%b cfg=%h required 0/00000000", s_axi.S_AXI_BVALID, sccb_cfg);
    end
    @(negedge ACLK);
    s_axi.S_AXI_AWVALID = 1'b0;
    checks++;
    if (s_axi.S_AXI_BVALID !== 1'b1 || sccb_cfg !== 32'h0000A5A5) begin
      errors++; $display("FAIL w_then_aw bvalid=%b cfg=%h required 1/0000a5a5", s_axi.S_AXI_BVALID, sccb_cfg);
    end
    @(negedge ACLK);
    axi_read(5'h04, d, r);
    checks++;
    if (d !== 32'h0000A5A5) begin
      errors++; $display("FAIL cfg_strobe_read got %h required 0000a5a5", d);
    end
  endtask

  task automatic test_frame_irq();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(5'h08, 32'h1, 4'hF, r);
    repeat (3) pulse_frame();
    axi_read(5'h14, d, r);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL frame_cnt3 got %h required 00000003", d); end
    axi_read(5'h10, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL status_sticky got %h required 00000001", d); end
    checks++;
    if (irq !== IRQ_EN) begin errors++; $display("FAIL irq_set got %b required %b", irq, IRQ_EN); end
    cam_busy = 1'b1;
    axi_read(5'h10, d, r);
    cam_busy = 1'b0;
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL status_busy got %h required 00000003", d); end
    axi_write(5'h10, 32'h1, 4'b1110, r);
    axi_read(5'h10, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL w1c_lane0_only got %h required 00000001", d); end
    axi_write(5'h10, 32'h1, 4'hF, r);
    axi_read(5'h10, d, r);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL w1c_clear got %h irq=%b required 00000000/0", d, irq);
    end
    @(negedge ACLK); frame_done = 1'b1;
    @(negedge ACLK); frame_done = 1'b0;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency_t got %b required 0", irq); end
    @(negedge ACLK);
    checks++;
    if (irq !== IRQ_EN) begin errors++; $display("FAIL irq_latency_t1 got %b required %b", irq, IRQ_EN); end
    axi_write(5'h10, 32'h1, 4'hF, r);
    @(negedge ACLK);
    s_axi.S_AXI_AWADDR = 5'h10; s_axi.S_AXI_AWVALID = 1'b1;
    s_axi.S_AXI_WDATA = 32'h1; s_axi.S_AXI_WSTRB = 4'hF; s_axi.S_AXI_WVALID = 1'b1;
    s_axi.S_AXI_BREADY = 1'b1; frame_done = 1'b1;
    @(negedge ACLK);
    s_axi.S_AXI_AWVALID = 1'b0; s_axi.S_AXI_WVALID = 1'b0; frame_done = 1'b0;
    checks++;
    if (s_axi.S_AXI_BVALID !== 1'b1) begin
      errors++; $display("FAIL coincide_bvalid got %b required 1", s_axi.S_AXI_BVALID);
    end
    axi_read(5'h10, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL set_wins got %h required 00000001", d); end
    axi_read(5'h14, d, r);
    checks++;
    if (d !== 32'd5) begin errors++; $display("FAIL frame_cnt5 got %h required 00000005", d); end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    logic [1:0]  r;
    bit ok;
    @(negedge ACLK);
    s_axi.S_AXI_AWADDR = 5'h0C; s_axi.S_AXI_AWVALID = 1'b1;
    s_axi.S_AXI_WDATA = 32'h55; s_axi.S_AXI_WSTRB = 4'hF; s_axi.S_AXI_WVALID = 1'b1;
    s_axi.S_AXI_ARADDR = 5'h0C; s_axi.S_AXI_ARVALID = 1'b1;
    s_axi.S_AXI_BREADY = 1'b0; s_axi.S_AXI_RREADY = 1'b0;
    @(negedge ACLK);
    s_axi.S_AXI_WDATA = 32'h99; s_axi.S_AXI_ARADDR = 5'h04;
    ok = 1;
    for (int k = 0; k < 5; k++) begin
      if (s_axi.S_AXI_BVALID !== 1'b1 || s_axi.S_AXI_RVALID !== 1'b1 ||
          s_axi.S_AXI_RDATA !== 32'h4 || s_axi.S_AXI_AWREADY !== 1'b0 ||
          s_axi.S_AXI_WREADY !== 1'b0 || s_axi.S_AXI_ARREADY !== 1'b0) ok = 0;
      @(negedge ACLK);
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL stall_hold bvalid=%b rvalid=%b rdata=%h required 1/1/00000004 with readies low",
        s_axi.S_AXI_BVALID, s_axi.S_AXI_RVALID, s_axi.S_AXI_RDATA);
    end
    s_axi.S_AXI_AWVALID = 1'b0; s_axi.S_AXI_WVALID = 1'b0; s_axi.S_AXI_ARVALID = 1'b0;
    s_axi.S_AXI_BREADY = 1'b1; s_axi.S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    checks++;
    if (s_axi.S_AXI_BVALID !== 1'b0 || s_axi.S_AXI_RVALID !== 1'b0) begin
      errors++; $display("FAIL stall_release bvalid=%b rvalid=%b required 0/0", s_axi.S_AXI_BVALID, s_axi.S_AXI_RVALID);
    end
    axi_read(5'h0C, d, r);
    checks++;
    if (d !== 32'h55) begin errors++; $display("FAIL stall_scratch got %h required 00000055", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(5'h00, 32'h1, 4'hF, r);
    @(negedge ACLK);
    s_axi.S_AXI_AWADDR = 5'h04; s_axi.S_AXI_AWVALID = 1'b1;
    s_axi.S_AXI_WDATA = 32'h77; s_axi.S_AXI_WSTRB = 4'hF; s_axi.S_AXI_WVALID = 1'b1;
    s_axi.S_AXI_ARADDR = 5'h0C; s_axi.S_AXI_ARVALID = 1'b1;
    s_axi.S_AXI_BREADY = 1'b0; s_axi.S_AXI_RREADY = 1'b0;
    @(negedge ACLK);
    s_axi.S_AXI_AWVALID = 1'b0; s_axi.S_AXI_WVALID = 1'b0; s_axi.S_AXI_ARVALID = 1'b0;
    #2 ARESETN = 1'b0;
    #1;
    checks++;
    if ({s_axi.S_AXI_BVALID, s_axi.S_AXI_RVALID, capture_en, s_axi.S_AXI_AWREADY} !== 4'b0000 ||
        s_axi.S_AXI_RDATA !== 32'h0 || sccb_cfg !== 32'h0) begin
      errors++; $display("FAIL async_reset bvalid=%b rvalid=%b cap=%b rdata=%h cfg=%h required all 0",
        s_axi.S_AXI_BVALID, s_axi.S_AXI_RVALID, capture_en, s_axi.S_AXI_RDATA, sccb_cfg);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    axi_read(5'h14, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_frame_cnt got %h required 00000000", d); end
    axi_read(5'h04, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_cfg got %h required 00000000", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic [1:0]  r;
    repeat (2) pulse_frame();
    axi_write(5'h14, 32'hDEADBEEF, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL ro_bresp got %b required 00", r); end
    axi_read(5'h14, d, r);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL ro_frame_cnt got %h required 00000002", d); end
    axi_write(5'h18, 32'h12345678, 4'hF, r);
    axi_read(5'h18, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL read_0x18 got %h/%b required 00000000/00", d, r); end
    axi_read(5'h1C, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL read_0x1c got %h/%b required 00000000/00", d, r); end
    axi_write(5'h00, 32'hFFFFFFFF, 4'b1000, r);
    axi_read(5'h00, d, r);
    checks++;
    if (d !== 32'hFF000000) begin errors++; $display("FAIL ctrl_strobe got %h required ff000000", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [1:0]  r;
    int n;
    @(negedge ACLK);
    s_axi.S_AXI_ARADDR = 5'h14; s_axi.S_AXI_ARVALID = 1'b1; s_axi.S_AXI_RREADY = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge ACLK);
      if (s_axi.S_AXI_RVALID === 1'b1) n++;
    end
    s_axi.S_AXI_ARVALID = 1'b0;
    checks++;
    if (n != 4) begin errors++; $display("FAIL b2b_rate got %0d reads in 8 cycles required 4", n); end
    @(negedge ACLK);
    axi_read(5'h14, d, r);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL b2b_no_side_effect got %h required 00000002", d); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_soft_rst();
    test_w_before_aw();
    test_frame_irq();
    test_stall();
    test_reset_mid();
    test_unmapped();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
